// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants: default line settings, oversampling
//                factor and receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Defaults shared with uart_transmitter so both ends agree on the line rate
    localparam int c_DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int c_DEFAULT_BAUD_RATE = 9600;
    localparam int c_OVERSAMPLE        = 16;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_tick_gen
//  Description : Free-running divider emitting a one-clock tick every DIV
//                clocks (when the count reaches DIV-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int             c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule : uart_rx_tick_gen
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver, 16x oversampled with mid-bit sampling.
//                Emits one-clock data_valid / frame_err pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = c_DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = c_DEFAULT_BAUD_RATE,
    parameter int OVERSAMPLE = c_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

    logic       r_rx_meta;
    logic       r_rx_s;
    logic       w_tick;

    logic [2:0] r_state,     w_state_nxt;
    logic [3:0] r_os_cnt,    w_os_cnt_nxt;
    logic [2:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    logic [7:0] r_data_out,  w_data_out_nxt;
    logic       r_valid,     w_valid_nxt;
    logic       r_ferr,      w_ferr_nxt;

    uart_rx_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // Synchronizer resets to the idle line level so reset never fakes a start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_os_cnt   <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_os_cnt   <= w_os_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_data_out <= w_data_out_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_os_cnt_nxt   = r_os_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = 1'b0;
        w_ferr_nxt     = 1'b0;

        if (w_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt  = c_ST_START;
                        w_os_cnt_nxt = 4'd0;
                    end
                end
                c_ST_START: begin
                    if (r_os_cnt == 4'd7) begin
                        // A start bit that is high again at its centre was noise
                        if (!r_rx_s) begin
                            w_state_nxt   = c_ST_DATA;
                            w_os_cnt_nxt  = 4'd0;
                            w_bit_cnt_nxt = 3'd0;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 4'd1;
                    end
                end
                c_ST_DATA: begin
                    if (r_os_cnt == 4'd15) begin
                        w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                        w_os_cnt_nxt  = 4'd0;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = c_ST_STOP;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 4'd1;
                    end
                end
                c_ST_STOP: begin
                    if (r_os_cnt == 4'd15) begin
                        w_os_cnt_nxt = 4'd0;
                        if (r_rx_s) begin
                            w_data_out_nxt = r_shift;
                            w_valid_nxt    = 1'b1;
                            w_state_nxt    = c_ST_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = c_ST_BREAK;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 4'd1;
                    end
                end
                c_ST_BREAK: begin
                    // Wait out a held-low line so it cannot re-trigger a start
                    if (r_rx_s) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != c_ST_IDLE);

endmodule : uart_receiver
`default_nettype wire
